// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: glitch-filtered clock, frame timeout, E0/F0 prefix folding, FIFO.
// Optional saturating error counter enabled by defining PS2_ERR_CNT_EN.
module ps2_keyboard_rx #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       brk,
    output logic       ext,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned EW    = 10;

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, strobe;
    logic [3:0]    flt_cnt;
    state_t        state;
    logic [3:0]    bit_cnt;
    logic [9:0]    sr;
    logic [TW-1:0] tcnt;
    logic          ext_p, brk_p;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Level filter: accept a new clock level after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (clr) begin
            filt    <= 1'b1;
            flt_cnt <= '0;
            strobe  <= 1'b0;
        end else if (clk_s2 != filt) begin
            if (flt_cnt == 4'(FILTER_LEN - 1)) begin
                filt    <= clk_s2;
                flt_cnt <= '0;
                strobe  <= ~clk_s2;
            end else begin
                flt_cnt <= flt_cnt + 4'd1;
                strobe  <= 1'b0;
            end
        end else begin
            flt_cnt <= '0;
            strobe  <= 1'b0;
        end
    end

    logic          stop_strb, frame_ok, tmo, err_c, byte_ok, push_c, pop_c;
    logic          full, wr_en, drop;
    logic [7:0]    byte_c;
    logic [EW-1:0] new_entry, head_n;
    logic [PW-1:0] rd_n;
    logic [CW-1:0] count_n;

    always_comb begin
        stop_strb = strobe && (state == RECV) && (bit_cnt == 4'd10);
        frame_ok  = ~sr[0] & dat_s2 & (^sr[9:1]);
        tmo       = (state == RECV) && !strobe && (tcnt == TW'(TIMEOUT - 1));
        err_c     = (stop_strb && !frame_ok) || tmo;
        byte_c    = sr[8:1];
        byte_ok   = stop_strb && frame_ok;
        push_c    = byte_ok && (byte_c != 8'hE0) && (byte_c != 8'hF0);
        new_entry = {ext_p, brk_p, byte_c};
        pop_c     = !rdn && ready;
        full      = (count == CW'(DEPTH));
        wr_en     = push_c && (!full || pop_c);
        drop      = push_c && full && !pop_c;
        count_n   = count + CW'(wr_en) - CW'(pop_c);
        rd_n      = rd_ptr + PW'(pop_c);
        // Forward the entry being written when it lands in the next head slot
        head_n    = (wr_en && (wr_ptr == rd_n)) ? new_entry : mem[rd_n];
    end

    // Frame FSM with mid-frame timeout
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tcnt    <= '0;
            sr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (strobe) begin
                        sr      <= {dat_s2, sr[9:1]};
                        bit_cnt <= 4'd1;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (strobe) begin
                        tcnt <= '0;
                        if (bit_cnt == 4'd10) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            sr      <= {dat_s2, sr[9:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (tmo) begin
                        tcnt    <= '0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prefix flags and error pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            ext_p     <= 1'b0;
            brk_p     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_c;
            if (err_c) begin
                ext_p <= 1'b0;
                brk_p <= 1'b0;
            end else if (byte_ok) begin
                if (byte_c == 8'hE0) begin
                    ext_p <= 1'b1;
                end else if (byte_c == 8'hF0) begin
                    brk_p <= 1'b1;
                end else begin
                    ext_p <= 1'b0;
                    brk_p <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= new_entry;
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ready    <= 1'b0;
            data     <= '0;
            brk      <= 1'b0;
            ext      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_n;
            count  <= count_n;
            if (drop) overflow <= 1'b1;
            else if (pop_c) overflow <= 1'b0;
            ready <= (count_n != '0);
            if (count_n != '0) {ext, brk, data} <= head_n;
            else {ext, brk, data} <= '0;
        end
    end

`ifdef PS2_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (clr) err_cnt <= '0;
        else if (err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver, successor to the fixed 8-entry receiver: glitch-filtered PS/2 clock, frame timeout and resynchronisation, configurable FIFO depth, and scan-code prefix decoding. E0 and F0 prefixes are folded into per-entry flags, so the CPU pops one entry per key event. It sits between the board PS/2 pins and the CPU I/O bus.

## Interface
- DEPTH_LOG2, 3: FIFO holds 2^DEPTH_LOG2 entries; all entries are usable.
- FILTER_LEN, 4: consecutive clk cycles a synchronised ps2_clk level must hold before it is accepted (1..15).
- TIMEOUT, 50000: clk cycles with no accepted falling edge, mid-frame, before the frame is abandoned. This is 1 ms at 50 MHz.
- clk  in  1  system clock, 50 MHz.
- clr  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- rdn  in  1  read strobe, active low. Pops one entry per clk cycle while low and ready=1.
- data  out  8  head-entry scan code. Reads 0 when the FIFO is empty.
- brk  out  1  head entry was preceded by F0 (key release). Reads 0 when empty.
- ext  out  1  head entry was preceded by E0 (extended key). Reads 0 when empty.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky: an entry was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a framing, parity or timeout error.
- err_cnt  out  8  saturating error count; see Configuration.

## Operation
- ps2_clk and ps2_data each pass through 2 synchroniser flops.
- Filter register `filt` (reset 1) takes the synchronised ps2_clk value once that value has differed from `filt` for FILTER_LEN consecutive cycles.
- Sample strobe: `filt` transitions 1->0. On the strobe cycle, the synchronised ps2_data is sampled.
- Frame FSM:
  - IDLE: the first strobe stores bit 0 (start) and moves to RECV with bit count = 1.
  - RECV: each strobe stores the next bit. Bits 1-8 are data, LSB first; bit 9 is parity; bit 10 is stop.
  - On the stop-bit strobe the frame is checked, then the FSM returns to IDLE. The frame is valid only if start=0, stop=1 and the XOR of data and parity is 1 (odd parity).
  - A valid frame passes its byte to the decoder. An invalid frame is discarded and pulses frame_err.
- Timeout: a cycle counter runs in RECV and clears on every strobe. When it reaches TIMEOUT, the FSM goes to IDLE, frame_err pulses and the partial frame is discarded. The counter does not run in IDLE.
- Decoder: holds two pending flags, ext_p and brk_p.
  - Byte E0 sets ext_p; byte F0 sets brk_p. Prefix bytes are never pushed.
  - Any other byte, including E1, pushes {ext_p, brk_p, byte} and clears both flags.
  - Any frame_err also clears both flags.
- FIFO: write pointer, read pointer, and an occupancy count that is DEPTH_LOG2+1 bits wide. Pointers wrap modulo 2^DEPTH_LOG2.
  - Push with count < 2^DEPTH_LOG2: entry is written.
  - Push when full with no simultaneous pop: entry is dropped and overflow is set.
  - Push and pop in the same cycle when full: both proceed, count is unchanged, overflow is not set.
  - Pop (rdn=0 and ready=1): read pointer advances and overflow clears. If a drop occurs in the same cycle as a pop, set wins.
  - Pop with ready=0 is ignored.
- Reset (clr=1 at a clk edge), including mid-frame or mid-prefix:
  - FSM to IDLE, bit count 0, timeout counter 0, filt=1, ext_p=brk_p=0.
  - FIFO empty.
  - All outputs 0: data, brk, ext, ready, overflow, frame_err, err_cnt.

## Timing
- Registered ps2_clk edge to strobe: 2 synchroniser cycles + FILTER_LEN + 1 cycle.
- Strobe of the stop bit to push: same cycle, registered. ready, data, brk and ext are valid the next cycle.
- Raw ps2_clk fall of the stop bit to ready=1: at most FILTER_LEN+5 clk cycles.
- After a pop edge, the outputs show the next entry, or 0 if the FIFO is now empty.
- frame_err is high for exactly 1 cycle per error.
- Glitches shorter than FILTER_LEN cycles produce no strobe.

## Configuration
- PS2_ERR_CNT_EN defined: err_cnt increments on each frame_err pulse and saturates at 255. It is cleared only by clr.
- PS2_ERR_CNT_EN undefined: the counter logic is removed and err_cnt is tied to 8'h00. All other behaviour is identical.

## Test plan
- Valid frame 0x1C (A press) -> one entry {ext=0, brk=0, data=1C}; ready rises within FILTER_LEN+5 cycles of the stop fall.
- Frames E0,F0,0x75 -> one entry {ext=1, brk=1, data=75}; no entries for E0 or F0; pop -> ready=0, data=0.
- Bad parity on 0x1C, then a valid 0x32 -> frame_err pulses once, no push, err_cnt=1 (macro on) or 0 (macro off); next entry {0,0,32}.
- Stop after 5 bits, idle for TIMEOUT+10 cycles, then a full 0x1C frame -> frame_err pulses once and entry 0x1C is received correctly.
- DEPTH_LOG2=2: push 5 codes with no read -> 4 entries, overflow=1, 5th dropped. Pop with a simultaneous push while full -> no overflow set, count stays 4.
- 2-cycle glitch low on ps2_clk while idle -> no strobe, FSM stays IDLE. Assert clr mid-frame -> all outputs 0 and the following frame decodes correctly.
